regfile_mp: RTL and testbench



---
 rtl/regfile_mp_pkg.sv | 25 ++
 rtl/regfile_scoreboard.sv | 56 +++++
 rtl/regfile_mp.sv | 89 ++++++++
 tb/tb_regfile_mp.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared register-file sizing and scoreboard types.
// Default GPR geometry macros live here so every file sees one definition.
`ifndef GPR_WIDTH
`define GPR_WIDTH 32
`endif
`ifndef GPR_NUM
`define GPR_NUM 32
`endif
`ifndef GPR_ADDR_SPACE
`define GPR_ADDR_SPACE 5
`endif

package regfile_mp_pkg;

  localparam int unsigned RF_MAX_RD = 4;
  localparam int unsigned RF_MAX_WR = 2;

  typedef enum logic [1:0] {
    SB_KEEP,
    SB_CLEAR,
    SB_SET,
    SB_FLUSH
  } sb_op_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per GPR.
// Flush beats claim, claim beats a same-cycle write-back clear.
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int NREGS = `GPR_NUM,
  parameter int AW    = `GPR_ADDR_SPACE,
  parameter int NWR   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NWR-1:0]    wr_en_i,
  input  logic [NWR*AW-1:0] wr_addr_i,
  input  logic              claim_en_i,
  input  logic [AW-1:0]     claim_addr_i,
  input  logic              flush_i,
  output logic [NREGS-1:0]  busy_o
);

  logic [NREGS-1:0] r_busy;
  sb_op_e           w_op [NREGS];

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      w_op[r] = SB_KEEP;
      for (int p = 0; p < NWR; p++) begin
        if (wr_en_i[p] && wr_addr_i[p*AW +: AW] == AW'(r))
          w_op[r] = SB_CLEAR;
      end
      if (claim_en_i && claim_addr_i == AW'(r))
        w_op[r] = SB_SET;
      if (flush_i)
        w_op[r] = SB_FLUSH;
    end
    // x0 never has a producer
    w_op[0] = SB_KEEP;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_busy <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        case (w_op[r])
          SB_SET:   r_busy[r] <= 1'b1;
          SB_CLEAR: r_busy[r] <= 1'b0;
          SB_FLUSH: r_busy[r] <= 1'b0;
          default:  r_busy[r] <= r_busy[r];
        endcase
      end
    end
  end

  assign busy_o = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port GPR file with write-back bypass and busy scoreboard.
// x0 reads as zero and is never busy.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int XLEN   = `GPR_WIDTH,
  parameter int NREGS  = `GPR_NUM,
  parameter int AW     = `GPR_ADDR_SPACE,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter bit BYPASS = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_val_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_val_i,
  input  logic                claim_en_i,
  input  logic [AW-1:0]       claim_addr_i,
  input  logic                flush_i
);

  logic [XLEN-1:0]  r_gpr [NREGS];
  logic [NREGS-1:0] w_busy;

  regfile_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW),
    .NWR   (NWR)
  ) u_sb (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .wr_en_i      (wr_en_i),
    .wr_addr_i    (wr_addr_i),
    .claim_en_i   (claim_en_i),
    .claim_addr_i (claim_addr_i),
    .flush_i      (flush_i),
    .busy_o       (w_busy)
  );

  // Later ports are applied last, so the highest index wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < NREGS; r++)
        r_gpr[r] <= '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en_i[p] && wr_addr_i[p*AW +: AW] != '0)
          r_gpr[wr_addr_i[p*AW +: AW]] <= wr_val_i[p*XLEN +: XLEN];
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   w_a;
    logic [XLEN-1:0] w_v;
    logic            w_b;
    logic            w_hit;

    assign w_a = rd_addr_i[k*AW +: AW];

    always_comb begin
      w_v   = r_gpr[w_a];
      w_b   = w_busy[w_a];
      w_hit = 1'b0;
      if (BYPASS) begin
        for (int p = 0; p < NWR; p++) begin
          if (wr_en_i[p] && wr_addr_i[p*AW +: AW] == w_a) begin
            w_v   = wr_val_i[p*XLEN +: XLEN];
            w_hit = 1'b1;
          end
        end
      end
      if (w_hit)
        w_b = 1'b0;
      if (w_a == '0) begin
        w_v = '0;
        w_b = 1'b0;
      end
    end

    assign rd_val_o[k*XLEN +: XLEN] = w_v;
    assign rd_busy_o[k]             = w_b;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: bypassing dual-write instance plus a non-bypass instance.
`timescale 1ns/1ps
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_val;
  logic [1:0]  a_rd_busy;
  logic [1:0]  a_wr_en;
  logic [9:0]  a_wr_addr;
  logic [63:0] a_wr_val;
  logic        a_claim_en;
  logic [4:0]  a_claim_addr;
  logic        a_flush;

  logic [4:0]  b_rd_addr;
  logic [31:0] b_rd_val;
  logic [0:0]  b_rd_busy;
  logic [0:0]  b_wr_en;
  logic [4:0]  b_wr_addr;
  logic [31:0] b_wr_val;
  logic        b_claim_en;
  logic [4:0]  b_claim_addr;
  logic        b_flush;

  int n_cmp = 0;
  int n_err = 0;

  regfile_mp #(
    .XLEN(32), .NREGS(32), .AW(5),
    .NRD(2), .NWR(2), .BYPASS(1'b1)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .rd_addr_i    (a_rd_addr),
    .rd_val_o     (a_rd_val),
    .rd_busy_o    (a_rd_busy),
    .wr_en_i      (a_wr_en),
    .wr_addr_i    (a_wr_addr),
    .wr_val_i     (a_wr_val),
    .claim_en_i   (a_claim_en),
    .claim_addr_i (a_claim_addr),
    .flush_i      (a_flush)
  );

  regfile_mp #(
    .XLEN(32), .NREGS(32), .AW(5),
    .NRD(1), .NWR(1), .BYPASS(1'b0)
  ) dut_nb (
    .clk_i        (clk),
    .rst_i        (rst),
    .rd_addr_i    (b_rd_addr),
    .rd_val_o     (b_rd_val),
    .rd_busy_o    (b_rd_busy),
    .wr_en_i      (b_wr_en),
    .wr_addr_i    (b_wr_addr),
    .wr_val_i     (b_wr_val),
    .claim_en_i   (b_claim_en),
    .claim_addr_i (b_claim_addr),
    .flush_i      (b_flush)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    a_wr_en    = '0;
    a_claim_en = 1'b0;
    a_flush    = 1'b0;
    b_wr_en    = '0;
    b_claim_en = 1'b0;
    b_flush    = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] p0, input logic [4:0] p1);
    a_rd_addr = {p1, p0};
  endtask

  initial begin
    idle();
    a_rd_addr = '0; a_wr_addr = '0; a_wr_val = '0; a_claim_addr = '0;
    b_rd_addr = '0; b_wr_addr = '0; b_wr_val = '0; b_claim_addr = '0;
    rd(5'd1, 5'd31);
    #3;
    chk("rst_val0", a_rd_val[31:0], 32'h0);
    chk("rst_val1", a_rd_val[63:32], 32'h0);
    chk("rst_busy", {30'd0, a_rd_busy}, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // plain write, visible after the edge
    a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd1}; a_wr_val = {32'h0, 32'h0000A5A5};
    tick();
    idle();
    #1;
    chk("wr_x1", a_rd_val[31:0], 32'h0000A5A5);

    // x0 protection
    rd(5'd0, 5'd0);
    a_wr_en = 2'b01; a_wr_addr = 10'd0; a_wr_val = {32'h0, 32'hDEADBEEF};
    a_claim_en = 1'b1; a_claim_addr = 5'd0;
    #1;
    chk("x0_val_same", a_rd_val[31:0], 32'h0);
    tick();
    idle();
    #1;
    chk("x0_val", a_rd_val[31:0], 32'h0);
    chk("x0_busy", {31'd0, a_rd_busy[0]}, 32'h0);

    // bypass: claim x5, then write-back with same-cycle read
    a_claim_en = 1'b1; a_claim_addr = 5'd5;
    tick();
    idle();
    rd(5'd0, 5'd5);
    #1;
    chk("x5_claimed", {31'd0, a_rd_busy[1]}, 32'h1);
    a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd5}; a_wr_val = {32'h0, 32'h00001234};
    b_rd_addr = 5'd5; b_wr_en = 1'b1; b_wr_addr = 5'd5; b_wr_val = 32'h00001234;
    #1;
    chk("byp_val", a_rd_val[63:32], 32'h00001234);
    chk("byp_busy", {31'd0, a_rd_busy[1]}, 32'h0);
    chk("nb_old", b_rd_val, 32'h0);
    tick();
    idle();
    #1;
    chk("nb_new", b_rd_val, 32'h00001234);
    chk("x5_after", a_rd_val[63:32], 32'h00001234);

    // dual write to x7, port1 wins
    rd(5'd7, 5'd0);
    a_wr_en = 2'b11; a_wr_addr = {5'd7, 5'd7}; a_wr_val = {32'h22, 32'h11};
    #1;
    chk("dual_byp", a_rd_val[31:0], 32'h22);
    tick();
    idle();
    #1;
    chk("dual_x7", a_rd_val[31:0], 32'h22);

    // scoreboard sequence on x3
    rd(5'd3, 5'd0);
    a_claim_en = 1'b1; a_claim_addr = 5'd3;
    tick();
    idle();
    #1;
    chk("x3_claim", {31'd0, a_rd_busy[0]}, 32'h1);
    a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd3}; a_wr_val = {32'h0, 32'h33};
    a_claim_en = 1'b1; a_claim_addr = 5'd3;
    tick();
    idle();
    #1;
    chk("x3_reclaim", {31'd0, a_rd_busy[0]}, 32'h1);
    chk("x3_val33", a_rd_val[31:0], 32'h33);
    a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd3}; a_wr_val = {32'h0, 32'h44};
    tick();
    idle();
    #1;
    chk("x3_retire", {31'd0, a_rd_busy[0]}, 32'h0);
    chk("x3_val44", a_rd_val[31:0], 32'h44);

    // flush beats claims
    a_claim_en = 1'b1; a_claim_addr = 5'd4;
    tick();
    a_claim_addr = 5'd9;
    tick();
    idle();
    rd(5'd4, 5'd9);
    #1;
    chk("pre_flush", {30'd0, a_rd_busy}, 32'h3);
    a_flush = 1'b1; a_claim_en = 1'b1; a_claim_addr = 5'd6;
    tick();
    idle();
    #1;
    chk("flush_4_9", {30'd0, a_rd_busy}, 32'h0);
    rd(5'd6, 5'd0);
    #1;
    chk("flush_x6", {31'd0, a_rd_busy[0]}, 32'h0);

    // async reset mid-run
    a_claim_en = 1'b1; a_claim_addr = 5'd8;
    tick();
    idle();
    rd(5'd7, 5'd8);
    #1;
    chk("x8_claim", {31'd0, a_rd_busy[1]}, 32'h1);
    rst = 1'b1;
    #1;
    chk("arst_x7", a_rd_val[31:0], 32'h0);
    chk("arst_busy", {30'd0, a_rd_busy}, 32'h0);
    chk("arst_nb", b_rd_val, 32'h0);
    a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd2}; a_wr_val = {32'h0, 32'hFF};
    a_claim_en = 1'b1; a_claim_addr = 5'd2;
    tick();
    idle();
    rst = 1'b0;
    rd(5'd2, 5'd1);
    #1;
    chk("post_x2", a_rd_val[31:0], 32'h0);
    chk("post_x1", a_rd_val[63:32], 32'h0);
    chk("post_busy", {30'd0, a_rd_busy}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
